// File: rtl/mem_interface_np.sv
// mem_interface_np
//   N-port dataflow wrapper around one shared memory array.
//   Every port collects an address token, a data token and a write-enable
//   token. It performs one read or write for each complete triple and returns
//   one response token after a fixed or pseudo-random latency.
//
// Ports
//   clk           clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   addr          per port p: [ADDR_W]=valid, [ADDR_W-1:0]=address
//   addr_stop     per-port backpressure to the address producer
//   in_data       per port: [DATA_W]=valid, [DATA_W-1:0]=write data
//   in_data_stop  per-port backpressure to the data producer
//   wren          per port: [1]=valid, [0]=1 write / 0 read
//   wren_stop     per-port backpressure to the write-enable producer
//   out_data      per port: [DATA_W]=valid, [DATA_W-1:0]=response data
//   down_stop     per-port backpressure from the response consumer
module mem_interface_np #(
    parameter int          NUM_PORTS = 4,
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 32,
    parameter int          MIN_LAT   = 3,
    parameter int          RAND_LAT  = 1,
    parameter int          RAND_BITS = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS*(ADDR_W+1)-1:0] addr,
    output logic [NUM_PORTS-1:0]            addr_stop,
    input  logic [NUM_PORTS*(DATA_W+1)-1:0] in_data,
    output logic [NUM_PORTS-1:0]            in_data_stop,
    input  logic [NUM_PORTS*2-1:0]          wren,
    output logic [NUM_PORTS-1:0]            wren_stop,
    output logic [NUM_PORTS*(DATA_W+1)-1:0] out_data,
    input  logic [NUM_PORTS-1:0]            down_stop
);

    localparam int LAT_MAX = MIN_LAT + ((RAND_LAT != 0) ? ((1 << RAND_BITS) - 1) : 0);
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam int DEPTH   = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_d;
    logic [CNT_W-1:0]  lat_new;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [NUM_PORTS-1:0] wr_en;
    logic [ADDR_W-1:0]    wr_addr [NUM_PORTS];
    logic [DATA_W-1:0]    wr_data [NUM_PORTS];

    // Fibonacci LFSR, taps 16,14,13,11; free-running so that every port
    // accepting on the same edge sees the same latency draw.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    always_comb begin
        lat_new = CNT_W'(MIN_LAT);
        if (RAND_LAT != 0) begin
            lat_new = CNT_W'(MIN_LAT + int'(lfsr_q[RAND_BITS-1:0]));
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        state_e            state_q;
        state_e            state_d;
        logic [CNT_W-1:0]  cnt_q;
        logic [CNT_W-1:0]  cnt_d;
        logic [CNT_W-1:0]  lat_q;
        logic [CNT_W-1:0]  lat_d;
        logic [ADDR_W-1:0] addr_q;
        logic [ADDR_W-1:0] addr_d;
        logic [DATA_W-1:0] wdata_q;
        logic [DATA_W-1:0] wdata_d;
        logic [DATA_W-1:0] odata_q;
        logic [DATA_W-1:0] odata_d;
        logic              we_q;
        logic              we_d;
        logic              ovalid_q;
        logic              ovalid_d;
        logic              accept;
        logic              fire;

        // A triple is consumed only when all three tokens are valid together.
        assign accept = (state_q == IDLE)
                      && addr[p*(ADDR_W+1) + ADDR_W]
                      && in_data[p*(DATA_W+1) + DATA_W]
                      && wren[2*p + 1];

        // cnt starts at 1 on the accept edge, so the access edge is exactly
        // lat edges after the accept edge.
        assign fire = (state_q == WAIT) && (cnt_q == lat_q);

        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            lat_d    = lat_q;
            addr_d   = addr_q;
            wdata_d  = wdata_q;
            we_d     = we_q;
            odata_d  = odata_q;
            ovalid_d = ovalid_q;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_d  = addr[p*(ADDR_W+1) +: ADDR_W];
                        wdata_d = in_data[p*(DATA_W+1) +: DATA_W];
                        we_d    = wren[2*p];
                        lat_d   = lat_new;
                        cnt_d   = CNT_W'(1);
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (fire) begin
                        // The array read here sees contents before this
                        // edge's writes, giving read-old behaviour.
                        odata_d  = we_q ? wdata_q : mem[addr_q];
                        ovalid_d = 1'b1;
                        state_d  = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (!down_stop[p]) begin
                        ovalid_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                lat_q    <= '0;
                addr_q   <= '0;
                wdata_q  <= '0;
                we_q     <= 1'b0;
                odata_q  <= '0;
                ovalid_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                lat_q    <= lat_d;
                addr_q   <= addr_d;
                wdata_q  <= wdata_d;
                we_q     <= we_d;
                odata_q  <= odata_d;
                ovalid_q <= ovalid_d;
            end
        end

        assign wr_en[p]   = fire && we_q;
        assign wr_addr[p] = addr_q;
        assign wr_data[p] = wdata_q;

        // Stops come from state only; no combinational path from inputs.
        assign addr_stop[p]    = (state_q != IDLE);
        assign in_data_stop[p] = (state_q != IDLE);
        assign wren_stop[p]    = (state_q != IDLE);
        assign out_data[p*(DATA_W+1) +: (DATA_W+1)] = {ovalid_q, odata_q};
    end

    // Descending scan: the last assignment wins, so the lowest port index
    // takes priority when several ports write the same address. A reset
    // forces every port to IDLE, so no aborted write can reach the array.
    always_ff @(posedge clk) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (wr_en[p]) begin
                mem[wr_addr[p]] <= wr_data[p];
            end
        end
    end

endmodule

// File: tb/tb_mem_interface_np.sv
// tb_mem_interface_np
//   Two instances: dutF with fixed latency 3 for directed scenarios, and
//   dutR with random latency in [3,10] for the randomized traffic phase.
//   Drivers push the expected response of every accepted request into a
//   per-port queue; a monitor pops and compares whenever a response appears.
module tb_mem_interface_np;

    localparam int NP = 4;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int AS = AW + 1;
    localparam int DS = DW + 1;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lmin;
        int          lmax;
    } expT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;

    logic [NP*AS-1:0] aF = '0;
    logic [NP*AS-1:0] aR = '0;
    logic [NP*DS-1:0] dF = '0;
    logic [NP*DS-1:0] dR = '0;
    logic [2*NP-1:0]  wF = '0;
    logic [2*NP-1:0]  wR = '0;
    logic [NP-1:0]    downF = '0;
    logic [NP-1:0]    downR = '0;
    logic [NP*DS-1:0] oF;
    logic [NP*DS-1:0] oR;
    logic [NP-1:0]    asF, dsF, wsF, asR, dsR, wsR;

    int  checks   = 0;
    int  failures = 0;
    bit  randDown = 0;

    expT         expQ [8][$];
    logic [31:0] modelMem [2][256];
    bit          known [2][256];
    logic [7:0]  prevV = '0;
    logic [31:0] curExp [8];
    int          latHit [16];
    int          respCountR = 0;

    mem_interface_np #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MIN_LAT(3),
        .RAND_LAT(0), .RAND_BITS(3), .LFSR_SEED(16'hACE1)
    ) dutF (
        .clk(clk), .rst_n(rst_n),
        .addr(aF), .addr_stop(asF),
        .in_data(dF), .in_data_stop(dsF),
        .wren(wF), .wren_stop(wsF),
        .out_data(oF), .down_stop(downF)
    );

    mem_interface_np #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MIN_LAT(3),
        .RAND_LAT(1), .RAND_BITS(3), .LFSR_SEED(16'hACE1)
    ) dutR (
        .clk(clk), .rst_n(rst_n),
        .addr(aR), .addr_stop(asR),
        .in_data(dR), .in_data_stop(dsR),
        .wren(wR), .wren_stop(wsR),
        .out_data(oR), .down_stop(downR)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Random consumer backpressure for dutR; ignored by the DUT outside RESP.
    always @(negedge clk) begin
        if (randDown) downR = 4'($urandom);
        else          downR = '0;
    end

    function automatic logic getValid(input int d, input int p);
        return (d == 0) ? oF[p*DS + DW] : oR[p*DS + DW];
    endfunction

    function automatic logic [31:0] getPay(input int d, input int p);
        return (d == 0) ? oF[p*DS +: DW] : oR[p*DS +: DW];
    endfunction

    function automatic logic [2:0] getStop(input int d, input int p);
        return (d == 0) ? {asF[p], dsF[p], wsF[p]} : {asR[p], dsR[p], wsR[p]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input int d, input int p, input bit va, input bit vd, input bit vw,
                               input logic [7:0] a, input logic [31:0] wd, input bit we);
        if (d == 0) begin
            aF[p*AS +: AS] = {va, a};
            dF[p*DS +: DS] = {vd, wd};
            wF[2*p +: 2]   = {vw, we};
        end else begin
            aR[p*AS +: AS] = {va, a};
            dR[p*DS +: DS] = {vd, wd};
            wR[2*p +: 2]   = {vw, we};
        end
    endtask

    // Wait for the port to be idle, present a full triple for one edge and
    // record the expected response from the reference memory.
    task automatic applyStimulus(input int d, input int p, input bit we, input logic [7:0] a,
                                 input logic [31:0] wd, input int lmin, input int lmax);
        int  n;
        expT e;
        n = 0;
        @(negedge clk);
        while (getStop(d, p) != 3'b000 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("[TB] FAIL idle timeout d%0d p%0d: stop still 0x%0h", d, p, getStop(d, p));
            return;
        end
        driveInputs(d, p, 1, 1, 1, a, wd, we);
        @(posedge clk);
        #1;
        e.acc  = cycle;
        e.lmin = lmin;
        e.lmax = lmax;
        e.data = we ? wd : modelMem[d][a];
        driveInputs(d, p, 0, 0, 0, 8'h00, 32'h0, 1'b0);
        expQ[d*4 + p].push_back(e);
        if (we) begin
            modelMem[d][a] = wd;
            known[d][a]    = 1;
        end
    endtask

    // Called right after an accept on dutF with down_stop low: stops are high
    // through three WAIT cycles and one RESP cycle, then drop.
    task automatic checkStopSeq(input int p);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stops busy p%0d n%0d", p, i), getStop(0, p), 3'b111);
        end
        @(negedge clk);
        checkOutput($sformatf("stops released p%0d", p), getStop(0, p), 3'b000);
    endtask

    task automatic waitDrain();
        int n;
        bit empty;
        n = 0;
        empty = 0;
        while (!empty && n < 3000) begin
            @(negedge clk);
            n++;
            empty = 1;
            for (int k = 0; k < 8; k++) if (expQ[k].size() != 0) empty = 0;
        end
        if (!empty) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain timeout: responses still outstanding, required none");
        end
    endtask

    task automatic randDriver(input int p);
        logic [7:0] a;
        bit         we;
        for (int i = 0; i < 250; i++) begin
            a  = {p[1:0], 3'b000, 3'($urandom_range(0, 7))};
            we = !known[1][a] || ($urandom_range(0, 1) == 1);
            applyStimulus(1, p, we, a, $urandom, 3, 10);
        end
    endtask

    // Monitor: a rising response valid pops the scoreboard; a held valid
    // must keep the same payload.
    always @(negedge clk) begin
        if (!rst_n) begin
            prevV = '0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                automatic int          d   = k / 4;
                automatic int          p   = k % 4;
                automatic logic        v   = getValid(d, p);
                automatic logic [31:0] pay = getPay(d, p);
                automatic expT         e;
                automatic int          lat;
                if (v && !prevV[k]) begin
                    if (expQ[k].size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected response d%0d p%0d: got payload 0x%0h, required no response", d, p, pay);
                    end else begin
                        e   = expQ[k].pop_front();
                        lat = cycle - e.acc;
                        checkOutput($sformatf("resp data d%0d p%0d", d, p), pay, e.data);
                        checks++;
                        if (lat < e.lmin || lat > e.lmax) begin
                            failures++;
                            $display("[TB] FAIL latency d%0d p%0d: got %0d, required %0d..%0d", d, p, lat, e.lmin, e.lmax);
                        end
                        if (d == 1) begin
                            respCountR++;
                            if (lat >= 0 && lat < 16) latHit[lat]++;
                        end
                        curExp[k] = e.data;
                    end
                end else if (v) begin
                    checkOutput($sformatf("held payload d%0d p%0d", d, p), pay, curExp[k]);
                end
                prevV[k] = v;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) latHit[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset out_data F", oF, '0);
        checkOutput("reset out_data R", oR, '0);
        checkOutput("reset stops F", {asF, dsF, wsF}, '0);
        checkOutput("reset stops R", {asR, dsR, wsR}, '0);
        rst_n = 1;
        @(negedge clk);

        // Partial valids are ignored
        driveInputs(0, 3, 1, 1, 0, 8'h44, 32'h12345678, 1'b1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("partial valids stay idle", getStop(0, 3), 3'b000);
        end
        driveInputs(0, 3, 0, 0, 0, 8'h00, 32'h0, 1'b0);

        // Write then read back with fixed latency
        applyStimulus(0, 0, 1, 8'h05, 32'hDEADBEEF, 3, 3);
        checkStopSeq(0);
        applyStimulus(0, 1, 0, 8'h05, 32'h0, 3, 3);
        checkStopSeq(1);
        waitDrain();

        // Held response under down_stop
        downF[2] = 1;
        applyStimulus(0, 2, 1, 8'h30, 32'hCAFE0003, 3, 3);
        repeat (4) @(negedge clk);
        checkOutput("held valid at response", getValid(0, 2), 1'b1);
        repeat (10) begin
            @(negedge clk);
            checkOutput("held valid", getValid(0, 2), 1'b1);
            checkOutput("held stops", getStop(0, 2), 3'b111);
        end
        downF[2] = 0;
        @(negedge clk);
        checkOutput("valid after release", getValid(0, 2), 1'b0);
        checkOutput("stops after release", getStop(0, 2), 3'b000);

        // Same-edge writes to one address: port 0 wins
        fork
            applyStimulus(0, 0, 1, 8'h10, 32'h00001111, 3, 3);
            applyStimulus(0, 3, 1, 8'h10, 32'h00003333, 3, 3);
        join
        modelMem[0][8'h10] = 32'h00001111;
        waitDrain();
        applyStimulus(0, 2, 0, 8'h10, 32'h0, 3, 3);
        waitDrain();

        // Reset while a write is in flight
        applyStimulus(0, 0, 1, 8'h20, 32'h00000000, 3, 3);
        waitDrain();
        applyStimulus(0, 0, 1, 8'h20, 32'hBADBAD00, 3, 3);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        checkOutput("abort out_data", oF, '0);
        checkOutput("abort stops", getStop(0, 0), 3'b000);
        rst_n = 1;
        checkOutput("aborted request pending", expQ[0].size(), 1);
        expQ[0].delete();
        modelMem[0][8'h20] = 32'h00000000;
        repeat (6) @(negedge clk);
        applyStimulus(0, 1, 0, 8'h20, 32'h0, 3, 3);
        waitDrain();

        // Randomized traffic on all ports with random latency and backpressure
        randDown = 1;
        for (int p = 0; p < NP; p++) begin
            fork
                automatic int pp = p;
                randDriver(pp);
            join_none
        end
        wait fork;
        randDown = 0;
        waitDrain();
        checkOutput("random response count", respCountR, 1000);
        for (int l = 3; l <= 10; l++) begin
            checks++;
            if (latHit[l] == 0) begin
                failures++;
                $display("[TB] FAIL latency coverage %0d: got 0 hits, required at least 1", l);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
